// File: rtl/lfm_pkg.sv
// Shared types and constants for the LFM frequency meter.
package lfm_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      FIRST  = 2'd1,
      LOCKED = 2'd2
   } lfm_state_t;

   localparam int SWEEP_SHIFT = 3;
   localparam int AVG_DEPTH   = 4;
   localparam int AVG_SHIFT   = 2;

endpackage

// File: rtl/lfm_hyst_cmp.sv
// Hysteresis comparator on qualified samples; rise flags the LOW->HIGH transition
// caused by the current sample.
module lfm_hyst_cmp #(
   parameter int IN_WIDTH = 16,
   parameter int HYST     = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic signed [IN_WIDTH-1:0] din,
   input  logic                       din_valid,
   output logic                       rise
);

   localparam logic signed [IN_WIDTH-1:0] POS_TH = IN_WIDTH'(HYST);
   localparam logic signed [IN_WIDTH-1:0] NEG_TH = -POS_TH;

   logic high_reg;
   logic at_high;
   logic at_low;

   assign at_high = (din >= POS_TH);
   assign at_low  = (din <= NEG_TH);
   assign rise    = din_valid && !high_reg && at_high;

   always_ff @(posedge clk) begin
      if (rst) begin
         high_reg <= 1'b0;
      end else if (din_valid) begin
         if (!high_reg && at_high)
            high_reg <= 1'b1;
         else if (high_reg && at_low)
            high_reg <= 1'b0;
      end
   end

endmodule

// File: rtl/lfm_freq_meter.sv
// Period meter between rising zero crossings with sweep-restart and loss-of-signal strobes.
// Build option: define LFM_FM_AVG_EN to report a 4-period running average instead of raw periods.
module lfm_freq_meter
   import lfm_pkg::*;
#(
   parameter int IN_WIDTH  = 16,
   parameter int CNT_WIDTH = 24,
   parameter int HYST      = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic signed [IN_WIDTH-1:0] din,
   input  logic                       din_valid,
   output logic [CNT_WIDTH-1:0]       period,
   output logic                       period_valid,
   output logic                       sweep_start,
   output logic                       lost,
   output logic                       locked
);

   localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = {{(CNT_WIDTH-1){1'b1}}, 1'b0};

   lfm_state_t           state_reg, state_next;
   logic [CNT_WIDTH-1:0] cnt_reg;
   logic [CNT_WIDTH-1:0] prev_reg;
   logic [CNT_WIDTH-1:0] period_reg;
   logic                 period_valid_reg;
   logic                 sweep_reg;
   logic                 lost_reg;

   logic                 rise;
   logic                 timeout;
   logic                 emit;
   logic                 sweep_hit;
   logic [CNT_WIDTH-1:0] measured;
   logic [CNT_WIDTH:0]   sweep_thresh;
   logic                 out_fire;
   logic [CNT_WIDTH-1:0] out_value;

   lfm_hyst_cmp #(
      .IN_WIDTH (IN_WIDTH),
      .HYST     (HYST)
   ) u_cmp (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .rise      (rise)
   );

   assign measured     = cnt_reg + 1'b1;
   assign timeout      = din_valid && !rise && (cnt_reg == CNT_LIMIT);
   assign emit         = rise && (state_reg != SEARCH);
   // One extra bit keeps prev + prev/8 from wrapping for large periods.
   assign sweep_thresh = {1'b0, prev_reg} + {1'b0, (prev_reg >> SWEEP_SHIFT)};
   assign sweep_hit    = (state_reg == LOCKED) && ({1'b0, measured} > sweep_thresh);

   always_comb begin
      state_next = state_reg;
      if (rise) begin
         case (state_reg)
            SEARCH:  state_next = FIRST;
            FIRST:   state_next = LOCKED;
            default: state_next = LOCKED;
         endcase
      end else if (timeout) begin
         state_next = SEARCH;
      end
   end

`ifdef LFM_FM_AVG_EN
   logic [CNT_WIDTH-1:0] hist_reg [AVG_DEPTH];
   logic [2:0]           fill_reg;
   logic [CNT_WIDTH+1:0] part_sum [AVG_DEPTH];
   logic [CNT_WIDTH+1:0] avg_full;

   // part_sum[AVG_DEPTH-1] is the sum including the period being emitted now.
   assign part_sum[0] = {2'b00, measured};
   genvar gi;
   generate
      for (gi = 1; gi < AVG_DEPTH; gi++) begin : g_sum
         assign part_sum[gi] = part_sum[gi-1] + {2'b00, hist_reg[gi-1]};
      end
   endgenerate

   assign avg_full  = part_sum[AVG_DEPTH-1] >> AVG_SHIFT;
   assign out_fire  = emit && (fill_reg >= 3'(AVG_DEPTH - 1));
   assign out_value = avg_full[CNT_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst || state_reg == SEARCH) begin
         fill_reg <= '0;
         for (int i = 0; i < AVG_DEPTH; i++)
            hist_reg[i] <= '0;
      end else if (emit) begin
         if (fill_reg < 3'(AVG_DEPTH))
            fill_reg <= fill_reg + 3'd1;
         hist_reg[0] <= measured;
         for (int i = 1; i < AVG_DEPTH; i++)
            hist_reg[i] <= hist_reg[i-1];
      end
   end
`else
   assign out_fire  = emit;
   assign out_value = measured;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= SEARCH;
         cnt_reg          <= '0;
         prev_reg         <= '0;
         period_reg       <= '0;
         period_valid_reg <= 1'b0;
         sweep_reg        <= 1'b0;
         lost_reg         <= 1'b0;
      end else begin
         state_reg        <= state_next;
         period_valid_reg <= out_fire;
         sweep_reg        <= out_fire && sweep_hit;
         lost_reg         <= timeout;
         if (din_valid)
            cnt_reg <= (rise || timeout) ? '0 : cnt_reg + 1'b1;
         if (emit)
            prev_reg <= measured;
         if (out_fire)
            period_reg <= out_value;
      end
   end

   assign period       = period_reg;
   assign period_valid = period_valid_reg;
   assign sweep_start  = sweep_reg;
   assign lost         = lost_reg;
   assign locked       = (state_reg == LOCKED);

endmodule

// File: tb/tb_lfm_freq_meter.sv
// Randomized bench for lfm_freq_meter against a sample-level behavioural model (raw-period build).
module tb_lfm_freq_meter;

   localparam int IW = 16;
   localparam int CW = 8;
   localparam int HY = 64;

   logic                 clk = 1'b0;
   logic                 rst;
   logic signed [IW-1:0] din;
   logic                 din_valid;
   logic [CW-1:0]        period;
   logic                 period_valid;
   logic                 sweep_start;
   logic                 lost;
   logic                 locked;

   int checks   = 0;
   int failures = 0;

   // Model: comparator level, samples since last crossing, crossings since search, last period.
   bit m_high;
   int m_since;
   int m_cross;
   int m_prev;
   int e_period;
   bit e_pv, e_sw, e_lost;

   int sweep_seen;
   int lost_seen;

   lfm_freq_meter #(
      .IN_WIDTH  (IW),
      .CNT_WIDTH (CW),
      .HYST      (HY)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .din          (din),
      .din_valid    (din_valid),
      .period       (period),
      .period_valid (period_valid),
      .sweep_start  (sweep_start),
      .lost         (lost),
      .locked       (locked)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   task automatic check_outputs();
      check_val("period", 32'(period), 32'(e_period));
      check_val("period_valid", 32'(period_valid), 32'(e_pv));
      check_val("sweep_start", 32'(sweep_start), 32'(e_sw));
      check_val("lost", 32'(lost), 32'(e_lost));
      check_val("locked", 32'(locked), 32'(m_cross >= 2));
   endtask

   task automatic step(input int d, input bit v);
      bit rise;
      int meas;
      din       = d[IW-1:0];
      din_valid = v;
      e_pv = 0; e_sw = 0; e_lost = 0;
      if (v) begin
         rise = !m_high && (d >= HY);
         if (rise) m_high = 1;
         else if (m_high && d <= -HY) m_high = 0;
         if (rise) begin
            meas    = m_since + 1;
            m_since = 0;
            m_cross++;
            if (m_cross >= 2) begin
               e_pv     = 1;
               e_period = meas;
               e_sw     = (m_cross >= 3) && (meas > m_prev + m_prev / 8);
               m_prev   = meas;
            end
         end else if (m_since == (1 << CW) - 2) begin
            e_lost  = 1;
            m_cross = 0;
            m_since = 0;
         end else begin
            m_since++;
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
      if (period_valid)
         $display("[%0t] period=%0d sweep_start=%0d", $time, period, sweep_start);
      if (lost)
         $display("[%0t] lost", $time);
      if (sweep_start) sweep_seen++;
      if (lost) lost_seen++;
   endtask

   task automatic do_reset(input bit busy);
      rst       = 1'b1;
      din_valid = busy;
      din       = busy ? 16'sd1000 : 16'sd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_high = 0; m_since = 0; m_cross = 0; m_prev = 0;
      e_period = 0; e_pv = 0; e_sw = 0; e_lost = 0;
      $display("[%0t] reset", $time);
      check_outputs();
   endtask

   // One square-wave period of p qualified samples; gap: 0 none, 1 every other clock, 2 random.
   task automatic square(input int p, input int amp, input int gap);
      for (int i = 0; i < p; i++) begin
         if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0))
            step($urandom_range(0, 4000) - 2000, 1'b0);
         step((i < p / 2) ? amp : -amp, 1'b1);
      end
   endtask

   task automatic noise(input int n);
      for (int i = 0; i < n; i++)
         step($urandom_range(0, 100) - 50, 1'b1);
   endtask

   initial begin
      int plist[8];
      rst = 1'b1; din_valid = 1'b0; din = '0;
      sweep_seen = 0; lost_seen = 0;
      do_reset(1'b0);

      // Steady tone, period 10, continuous and half-rate qualification
      for (int k = 0; k < 6; k++) square(10, 1000, 0);
      check_val("locked_tone", 32'(locked), 32'd1);
      for (int k = 0; k < 6; k++) square(10, 1000, 1);

      // Sub-threshold noise
      do_reset(1'b0);
      noise(200);
      check_val("noise_unlocked", 32'(locked), 32'd0);

      // Chirp restart: only the jump to 120 is a sweep
      do_reset(1'b0);
      sweep_seen = 0;
      plist = '{100, 100, 90, 80, 120, 119, 119, 10};
      foreach (plist[k]) square(plist[k], 1500, 0);
      check_val("sweep_count", 32'(sweep_seen), 32'd1);

      // Loss of signal and re-lock
      do_reset(1'b0);
      lost_seen = 0;
      for (int k = 0; k < 4; k++) square(20, 800, 0);
      for (int k = 0; k < 300; k++) step(0, 1'b1);
      check_val("lost_count", 32'(lost_seen), 32'd1);
      check_val("lost_unlocked", 32'(locked), 32'd0);
      for (int k = 0; k < 3; k++) square(30, 800, 0);
      check_val("relocked", 32'(locked), 32'd1);

      // Reset while locked and mid-high-half
      for (int k = 0; k < 3; k++) square(10, 1000, 0);
      for (int k = 0; k < 3; k++) step(1000, 1'b1);
      do_reset(1'b1);
      for (int k = 0; k < 4; k++) square(12, 1000, 0);

      // Randomized mix of periods, amplitudes at threshold, gaps, noise and resets
      for (int k = 0; k < 60; k++) begin
         case ($urandom_range(0, 19))
            0:       do_reset($urandom_range(0, 1) == 1);
            1:       noise($urandom_range(10, 300));
            default: square($urandom_range(4, 200),
                            ($urandom_range(0, 4) == 0) ? HY : $urandom_range(HY, 20000),
                            $urandom_range(0, 2));
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
